// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS fetch stage.
//   OPCODE_SPECIAL / FUNCT_SYSCALL : encoding used to detect a syscall word
//   INST_NOP                       : value presented on the IF output when empty
//   fetch_state_t                  : fetch FSM state encoding
//   fetch_entry_t                  : {inst, pc, halt} payload carried to IF/ID
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [5:0]      OPCODE_SPECIAL = 6'h00;
    localparam logic [5:0]      FUNCT_SYSCALL  = 6'h0C;
    localparam logic [XLEN-1:0] INST_NOP       = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            halt;
    } fetch_entry_t;

    // True when the opcode/funct fields encode a syscall.
    function automatic logic is_syscall(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OPCODE_SPECIAL) && (funct == FUNCT_SYSCALL);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry holding register for a fetched {inst, pc, halt}
// that arrived while the IF output registers were stalled.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_load       : capture i_entry (wins over i_unload)
//   i_unload     : entry consumed, mark empty
//   i_flush      : discard contents (wins over everything)
//   i_entry      : payload to capture
//   o_valid      : buffer holds an entry
//   o_entry      : held payload
module fetch_skid_buffer
    import mips_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_unload,
    input  logic         i_flush,
    input  fetch_entry_t i_entry,
    output logic         o_valid,
    output fetch_entry_t o_entry
);

    logic         r_valid;
    fetch_entry_t r_entry;

    // Occupancy and payload of the single entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_entry <= i_entry;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage, producer side of the IF/ID register.
// Owns the PC, issues word reads over a req/ack handshake, buffers one word
// while decode stalls, handles branch/jump redirects and stops after a syscall.
//   clk, rst              : clock, asynchronous active-high reset
//   stall_id              : decode cannot accept; hold IF outputs
//   redirect_valid/_pc    : taken branch/jump; flush and refetch at target
//   imem_req/_addr        : read request and word address (held until ack)
//   imem_ack/_rdata       : read completion and instruction word
//   inst_if/pc_if         : instruction and its PC toward IF/ID
//   inst_valid_if         : inst_if holds a real instruction
//   halted_controller_if  : inst_if is a syscall
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_if,
    output logic        inst_valid_if,
    output logic [31:0] pc_if,
    output logic        halted_controller_if
);

    localparam logic [XLEN-1:0] PC_STEP       = XLEN'(4);
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] RESET_PC_WORD = RESET_PC & PC_ALIGN_MASK;

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_addr;
    logic            r_req;

    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc_out;
    logic            r_valid;
    logic            r_halt;

    logic            w_skid_valid;
    fetch_entry_t    w_skid_entry;
    fetch_entry_t    w_fetched;

    logic [XLEN-1:0] w_redirect_target;
    logic [XLEN-1:0] w_pc_inc;
    logic            w_ack;
    logic            w_ack_fetch;
    logic            w_out_free;
    logic            w_skid_load;
    logic            w_skid_unload;
    logic            w_skid_full_next;
    logic            w_out_valid_next;
    logic            w_raise_req;

    assign w_redirect_target = redirect_pc & PC_ALIGN_MASK;
    assign w_pc_inc          = r_pc + PC_STEP;

    // An ack only counts against a request we actually have outstanding.
    assign w_ack       = r_req && imem_ack;
    assign w_ack_fetch = w_ack && (r_state == ST_FETCH) && !redirect_valid;

    // Output registers can take a new word if empty or being consumed now.
    assign w_out_free = !r_valid || !stall_id;

    assign w_fetched.inst = imem_rdata;
    assign w_fetched.pc   = r_addr;
    assign w_fetched.halt = is_syscall(imem_rdata[31:26], imem_rdata[5:0]);

    // Skid takes the word when the output is blocked, or to keep ordering
    // behind an entry that is being moved out in the same cycle.
    assign w_skid_load   = w_ack_fetch && (!w_out_free || w_skid_valid);
    assign w_skid_unload = !redirect_valid && w_out_free && w_skid_valid;

    // Occupancy after this edge; used to decide whether to issue a new read.
    assign w_skid_full_next = !redirect_valid &&
                              (w_skid_load || (w_skid_valid && !w_skid_unload));
    assign w_out_valid_next = !redirect_valid &&
                              (!w_out_free || w_skid_valid || w_ack_fetch);

    // Only request when the returning word is guaranteed a place to land.
    assign w_raise_req = !w_skid_full_next && !(w_out_valid_next && stall_id);

    // Fetch FSM, program counter and request/address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC_WORD;
            r_addr  <= RESET_PC_WORD;
            r_req   <= 1'b0;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
            // An unacked read must still complete; its data is thrown away.
            if (r_req && !imem_ack) begin
                r_state <= ST_DRAIN;
            end else begin
                r_state <= ST_FETCH;
                r_req   <= 1'b1;
                r_addr  <= w_redirect_target;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_ack) begin
                        r_pc <= w_pc_inc;
                        if (w_fetched.halt) begin
                            r_state <= ST_HALTED;
                            r_req   <= 1'b0;
                        end else begin
                            r_req  <= w_raise_req;
                            r_addr <= w_pc_inc;
                        end
                    end else if (!r_req) begin
                        r_req  <= w_raise_req;
                        r_addr <= r_pc;
                    end
                end
                ST_DRAIN: begin
                    if (w_ack) begin
                        r_state <= ST_FETCH;
                        r_req   <= w_raise_req;
                        r_addr  <= r_pc;
                    end
                end
                ST_HALTED: begin
                    r_req <= 1'b0;
                end
                default: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // IF output registers: skid entry drains first, then fresh memory data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst   <= INST_NOP;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
            r_halt   <= 1'b0;
        end else if (redirect_valid) begin
            r_inst  <= INST_NOP;
            r_valid <= 1'b0;
            r_halt  <= 1'b0;
        end else if (w_out_free) begin
            if (w_skid_valid) begin
                r_inst   <= w_skid_entry.inst;
                r_pc_out <= w_skid_entry.pc;
                r_halt   <= w_skid_entry.halt;
                r_valid  <= 1'b1;
            end else if (w_ack_fetch) begin
                r_inst   <= w_fetched.inst;
                r_pc_out <= w_fetched.pc;
                r_halt   <= w_fetched.halt;
                r_valid  <= 1'b1;
            end else begin
                r_inst  <= INST_NOP;
                r_valid <= 1'b0;
                r_halt  <= 1'b0;
            end
        end
    end

    fetch_skid_buffer u_skid (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_flush  (redirect_valid),
        .i_entry  (w_fetched),
        .o_valid  (w_skid_valid),
        .o_entry  (w_skid_entry)
    );

    assign imem_req             = r_req;
    assign imem_addr            = r_addr;
    assign inst_if              = r_inst;
    assign pc_if                = r_pc_out;
    assign inst_valid_if        = r_valid;
    assign halted_controller_if = r_halt;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and a randomized run
// checked against a program-order model of the fetched instruction stream.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_id;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_if;
    logic        inst_valid_if;
    logic [31:0] pc_if;
    logic        halted_controller_if;

    int n_checks = 0;
    int n_err    = 0;

    // memory model state
    int          mem_cnt  = 0;
    int          mem_lat  = 0;
    bit          mem_rand = 0;
    bit          mem_in_req = 0;
    logic [31:0] mem_req_addr = 0;
    bit          sys_en   = 0;
    logic [31:0] sys_addr = 0;
    bit          rand_sys = 0;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall_id             (stall_id),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ack             (imem_ack),
        .imem_rdata           (imem_rdata),
        .inst_if              (inst_if),
        .inst_valid_if        (inst_valid_if),
        .pc_if                (pc_if),
        .halted_controller_if (halted_controller_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'h0000_0100)                 w = 32'h2008_0001;
        else if (a == 32'h0000_0104)            w = 32'h2009_0002;
        else if (sys_en && a == sys_addr)       w = 32'h0000_000C;
        else if (rand_sys && a[6:2] == 5'h1F)   w = 32'h0000_000C;
        else                                    w = {6'h23, a[27:2]};
        return w;
    endfunction

    function automatic logic is_sys(input logic [31:0] w);
        return (w[31:26] == 6'h00) && (w[5:0] == 6'h0C);
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Memory responder: acks after mem_lat wait cycles, checks address hold.
    task automatic drive_mem();
        if (!imem_req || rst) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
            mem_cnt    = 0;
            mem_in_req = 0;
        end else begin
            if (mem_in_req) begin
                chk32("addr_stable", imem_addr, mem_req_addr);
            end else begin
                mem_in_req   = 1;
                mem_req_addr = imem_addr;
                mem_cnt      = 0;
                if (mem_rand) mem_lat = $urandom_range(0, 3);
            end
            if (mem_cnt >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                mem_in_req = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                mem_cnt++;
            end
        end
    endtask

    task automatic tick(input logic s, input logic r, input logic [31:0] rp);
        @(posedge clk);
        #1;
        stall_id       = s;
        redirect_valid = r;
        redirect_pc    = rp;
        drive_mem();
    endtask

    task automatic do_reset(input int lat);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        mem_lat  = lat;
        stall_id = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_mem();
    endtask

    typedef struct {
        logic        stall;
        logic        red;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_halt;
    } vec_t;

    vec_t vec[11];

    initial begin
        logic        found;
        logic [31:0] exp_pc;
        logic [31:0] w;
        logic        s, r, model_on, halted_m;
        logic [31:0] rp;
        int          consumed;

        // cycle-by-cycle expectations from reset, same-cycle ack memory
        vec[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0,         1'b0};
        vec[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 32'h2008_0001, 1'b0};
        vec[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104, 32'h2009_0002, 1'b0};
        vec[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h104, 32'h2009_0002, 1'b0};
        vec[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h104, 32'h2009_0002, 1'b0};
        vec[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h104, 32'h2009_0002, 1'b0};
        vec[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h104, 32'h2009_0002, 1'b0};
        vec[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h108, 32'h8C00_0042, 1'b0};
        vec[8]  = '{1'b0, 1'b1, 32'h203, 1'b1, 32'h110, 1'b1, 32'h10C, 32'h8C00_0043, 1'b0};
        vec[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   32'h0,         1'b0};
        vec[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200, 32'h8C00_0080, 1'b0};

        rst = 1'b1;
        stall_id = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", inst_valid_if, 1'b0);
        chk32("rst_inst", inst_if, 32'h0);
        chk32("rst_pc", pc_if, 32'h0);
        chk1("rst_halt", halted_controller_if, 1'b0);
        rst = 1'b0;
        drive_mem();

        // vector table
        for (int i = 0; i < 11; i++) begin
            tick(vec[i].stall, vec[i].red, vec[i].rpc);
            chk1($sformatf("v%0d_req", i), imem_req, vec[i].e_req);
            if (vec[i].e_req) chk32($sformatf("v%0d_addr", i), imem_addr, vec[i].e_addr);
            chk1($sformatf("v%0d_valid", i), inst_valid_if, vec[i].e_valid);
            chk32($sformatf("v%0d_inst", i), inst_if, vec[i].e_inst);
            if (vec[i].e_valid) chk32($sformatf("v%0d_pc", i), pc_if, vec[i].e_pc);
            chk1($sformatf("v%0d_halt", i), halted_controller_if, vec[i].e_halt);
        end

        // three wait cycles before ack, then an async reset mid-wait
        do_reset(3);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, 32'h0);
            chk1($sformatf("wait%0d_req", k), imem_req, 1'b1);
            chk32($sformatf("wait%0d_addr", k), imem_addr, 32'h100);
            chk1($sformatf("wait%0d_valid", k), inst_valid_if, 1'b0);
        end
        tick(1'b0, 1'b0, 32'h0);
        chk1("lat_valid", inst_valid_if, 1'b1);
        chk32("lat_pc", pc_if, 32'h100);
        chk32("lat_inst", inst_if, 32'h2008_0001);
        tick(1'b0, 1'b0, 32'h0);
        chk1("lat_one_cycle", inst_valid_if, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_req", imem_req, 1'b0);
        chk1("arst_valid", inst_valid_if, 1'b0);
        chk32("arst_inst", inst_if, 32'h0);
        chk32("arst_pc", pc_if, 32'h0);
        chk1("arst_halt", halted_controller_if, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_mem();

        // redirect while a read is pending: drain and discard, refetch at 0x200
        tick(1'b0, 1'b0, 32'h0);
        chk32("drain_old_addr", imem_addr, 32'h100);
        tick(1'b0, 1'b1, 32'h0000_0203);
        tick(1'b0, 1'b0, 32'h0);
        chk1("drain_req_held", imem_req, 1'b1);
        chk32("drain_addr_held", imem_addr, 32'h100);
        tick(1'b0, 1'b0, 32'h0);
        chk1("drain_bubble", inst_valid_if, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        chk1("drain_discard", inst_valid_if, 1'b0);
        chk1("drain_new_req", imem_req, 1'b1);
        chk32("drain_new_addr", imem_addr, 32'h200);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (inst_valid_if) found = 1'b1;
        end
        chk1("drain_first_valid", found, 1'b1);
        chk32("drain_first_pc", pc_if, 32'h200);
        chk32("drain_first_inst", inst_if, 32'h8C00_0080);

        // syscall halts fetch; a redirect resumes it
        mem_lat  = 0;
        sys_en   = 1;
        sys_addr = 32'h80;
        tick(1'b0, 1'b1, 32'h80);
        tick(1'b0, 1'b0, 32'h0);
        chk32("sys_addr", imem_addr, 32'h80);
        tick(1'b0, 1'b0, 32'h0);
        chk1("sys_valid", inst_valid_if, 1'b1);
        chk32("sys_inst", inst_if, 32'h0000_000C);
        chk1("sys_halt", halted_controller_if, 1'b1);
        chk1("sys_req_off", imem_req, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, 32'h0);
            chk1($sformatf("halted%0d_req", k), imem_req, 1'b0);
            chk1($sformatf("halted%0d_valid", k), inst_valid_if, 1'b0);
        end
        tick(1'b0, 1'b1, 32'h40);
        chk1("resume_req_before", imem_req, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        chk1("resume_req", imem_req, 1'b1);
        chk32("resume_addr", imem_addr, 32'h40);
        tick(1'b0, 1'b0, 32'h0);
        chk32("resume_pc", pc_if, 32'h40);
        chk32("resume_inst", inst_if, 32'h8C00_0010);
        chk1("resume_halt", halted_controller_if, 1'b0);
        sys_en = 0;

        // PC wrap at the top of the address space; low target bits ignored
        tick(1'b0, 1'b1, 32'hFFFF_FFFE);
        tick(1'b0, 1'b0, 32'h0);
        chk32("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0);
        chk32("wrap_addr_zero", imem_addr, 32'h0);
        chk32("wrap_pc_top", pc_if, 32'hFFFF_FFFC);
        chk32("wrap_inst_top", inst_if, 32'h8FFF_FFFF);
        tick(1'b0, 1'b0, 32'h0);
        chk32("wrap_pc_zero", pc_if, 32'h0);
        chk32("wrap_inst_zero", inst_if, 32'h8C00_0000);

        // randomized run against a program-order model
        rand_sys = 1;
        mem_rand = 1;
        model_on = 0;
        halted_m = 0;
        exp_pc   = 32'h0;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            s  = ($urandom_range(0, 9) < 3);
            r  = (i == 0) || ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else                           rp = 32'($urandom_range(0, 4095));
            if (i == 0) rp = 32'h400;
            tick(s, r, rp);
            if (!inst_valid_if) chk32("rand_nop", inst_if, 32'h0);
            if (model_on) begin
                if (halted_m) begin
                    chk1("rand_halt_req", imem_req, 1'b0);
                    chk1("rand_halt_valid", inst_valid_if, 1'b0);
                end
                if (inst_valid_if && !s && !r) begin
                    w = mem_word(exp_pc);
                    chk32("rand_pc", pc_if, exp_pc);
                    chk32("rand_inst", inst_if, w);
                    chk1("rand_halt", halted_controller_if, is_sys(w));
                    consumed++;
                    if (is_sys(w)) halted_m = 1;
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (r) begin
                exp_pc   = rp & 32'hFFFF_FFFC;
                halted_m = 0;
                model_on = 1;
            end
        end
        chk1("rand_progress", consumed >= 200, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline: the producer side of the IF/ID pipeline register. Owns the program counter and issues word reads to instruction memory over a req/ack handshake. Presents each fetched instruction, its PC and a halt flag to the IF/ID register, honouring decode-stage stalls and branch/jump redirects. Stops fetching after a `syscall` is fetched.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall_id`  in  1  decode cannot accept; hold the current IF outputs.
- `redirect_valid`  in  1  branch/jump resolved taken; flush and refetch.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored and forced to 0.
- `imem_req`  out  1  instruction-memory read request.
- `imem_addr`  out  32  word-aligned read address; stable while `imem_req` is high.
- `imem_ack`  in  1  read data valid this cycle; may arrive in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word, sampled only when `imem_ack` is high.
- `inst_if`  out  32  instruction to IF/ID; 0 (nop) when not valid.
- `inst_valid_if`  out  1  `inst_if` holds a real instruction.
- `pc_if`  out  32  PC of `inst_if`.
- `halted_controller_if`  out  1  `inst_if` is a `syscall`; travels with the instruction.

## Operation
- Reset values: `inst_if`=0, `inst_valid_if`=0, `pc_if`=0, `halted_controller_if`=0, `imem_req`=0, internal pc=`RESET_PC`, skid empty, state FETCH.
- States: FETCH, DRAIN, HALTED.
- FETCH: raise `imem_req` with `imem_addr`=pc when the skid is empty and not (`inst_valid_if` and `stall_id`). Once raised, hold req and addr until `imem_ack`.
- On ack in FETCH:
  - word goes to the output registers if they are free or being consumed (`stall_id`=0); otherwise it goes to the one-entry skid;
  - pc <= pc+4, with a 32-bit wrap: 32'hFFFF_FFFC → 0.
- Stall: while `stall_id`=1, `inst_if`/`pc_if`/`inst_valid_if`/`halted_controller_if` hold. When `stall_id` falls, the skid contents move to the output in the next cycle.
- Halt: a fetched word with opcode 6'h00 and funct 6'h0C sets the halt flag with that instruction. FSM goes to HALTED and no further requests are issued.
- Redirect (priority over stall and ack data):
  - `inst_valid_if`, `halted_controller_if` and the skid are cleared next cycle;
  - pc <= {`redirect_pc`[31:2],2'b00};
  - if a request is outstanding and not acked this cycle, go to DRAIN; otherwise go to FETCH, including from HALTED.
- DRAIN: hold the old req/addr until `imem_ack`, discard that data, then go to FETCH at the redirect pc. A second redirect in DRAIN overwrites the target.

## Timing
- First request in the first cycle after `rst` deasserts.
- Latency: `imem_ack` in cycle N → `inst_valid_if`=1 in cycle N+1.
- Throughput: with same-cycle ack and no stalls, one instruction per cycle.
- Redirect in cycle N: bubble (`inst_valid_if`=0) in N+1. With a same-cycle-ack memory, the target address appears on `imem_addr` in N+1.
- `rst` mid-request drops `imem_req` immediately and discards any later ack.
- Simultaneous `redirect_valid` and `imem_ack`: data discarded, no DRAIN.

## Structure
- `mips_pkg`: `OPCODE_SPECIAL`, `FUNCT_SYSCALL`, `INST_NOP`, and the fetch-state enum.
- One sub-module, `fetch_skid_buffer`: one-entry holding register for {inst, pc, halt} with load/unload/flush inputs and async active-high reset.
- PC register, FSM and output registers live in `fetch_unit`.

## Test plan
- Reset, `RESET_PC`=0x100, same-cycle ack, instructions 0x2008_0001 and 0x2009_0002 → `pc_if` 0x100 then 0x104 on consecutive cycles, both valid.
- Ack after 3 wait cycles → `imem_addr` stable across the wait; `inst_valid_if` is 0 during the wait and 1 for exactly one cycle after the ack.
- `stall_id` high for 4 cycles while an ack lands → output held; skid captures the next word; it appears the cycle after `stall_id` falls; no word lost or duplicated.
- Redirect to 0x0000_0203 while a request is pending → old data discarded; next request address is 0x200; bubble observed.
- Fetch 0x0000_000C → `halted_controller_if`=1 with it and `imem_req` stays 0 afterwards. A later redirect to 0x40 resumes fetch at 0x40.
- pc 0xFFFF_FFFC fetch → next `imem_addr` 0x0; `rst` pulse mid-wait → all outputs return to reset values asynchronously.
